pipeline_adder_stages: RTL

- Multi-stage pipelined ripple adder. Computes a + b + cin over STAGES register stages, one WIDTH/STAGES-bit slice per stage, with the carry passed between stages.
- Consumes the registered pause/flush pair from the pipeline control block. pause stalls every stage; flush invalidates every stage.
- Sits between the operand source (testbench or switch/register front end) and the result sink (display or checker).

---
 rtl/pipeline_adder_stages_pkg.sv | 17 +
 rtl/pipeline_adder_stages_adder_slice.sv | 37 +++
 rtl/pipeline_adder_stages.sv | 95 +++++++++
 3 files changed

// File: rtl/pipeline_adder_stages_pkg.sv
// Shared constants and the stage record for the pipelined ripple adder.
// The default slice width is derived from the default width and stage count.
package pipeline_adder_stages_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int SW         = DEF_WIDTH / DEF_STAGES;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a_rem;
    logic [DEF_WIDTH-1:0] b_rem;
    logic [DEF_WIDTH-1:0] sum_done;
  } stage_t;

endpackage

// File: rtl/pipeline_adder_stages_adder_slice.sv
// Registered DATA_W-bit adder slice with carry-in and carry-out.
// The slice loads only when the enclosing pipeline advances.
module adder_slice
  import pipeline_adder_stages_pkg::*;
#(
  parameter int DATA_W = SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout
);

  logic [DATA_W:0]   w_add;
  logic [DATA_W-1:0] r_sum;
  logic              r_cout;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_sum  <= w_add[DATA_W-1:0];
      r_cout <= w_add[DATA_W];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: rtl/pipeline_adder_stages.sv
// Pipelined ripple adder: one slice per stage, carry handed stage to stage.
// pause freezes every stage; flush clears all valid bits and wins over pause.
module pipeline_adder_stages
  import pipeline_adder_stages_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  input  logic             pause,
  input  logic             flush,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int SLW = WIDTH / STAGES;

  logic                          w_en;
  logic [STAGES-1:0][SLW-1:0]    w_ssum;
  logic [STAGES-1:0]             w_scout;
  logic [STAGES-1:0][WIDTH-1:0]  w_done;

  // Operands still to be added travel right-aligned; completed low slices in r_s.
  logic [WIDTH-1:0]  r_a [STAGES-1];
  logic [WIDTH-1:0]  r_b [STAGES-1];
  logic [WIDTH-1:0]  r_s [1:STAGES-1];
  logic [STAGES-1:0] r_v;

  assign in_ready = !pause || flush;
  assign w_en     = in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLW-1:0] w_op_a;
    logic [SLW-1:0] w_op_b;
    logic           w_c;

    if (k == 0) begin : g_first
      assign w_op_a    = a[SLW-1:0];
      assign w_op_b    = b[SLW-1:0];
      assign w_c       = cin;
      assign w_done[0] = {{(WIDTH-SLW){1'b0}}, w_ssum[0]};
    end else begin : g_rest
      assign w_op_a    = r_a[k-1][SLW-1:0];
      assign w_op_b    = r_b[k-1][SLW-1:0];
      assign w_c       = w_scout[k-1];
      assign w_done[k] = r_s[k] | ({{(WIDTH-SLW){1'b0}}, w_ssum[k]} << (k*SLW));
    end

    adder_slice #(.DATA_W(SLW)) u_slice (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .i_a   (w_op_a),
      .i_b   (w_op_b),
      .i_cin (w_c),
      .o_sum (w_ssum[k]),
      .o_cout(w_scout[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < STAGES-1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 1; k < STAGES; k++) r_s[k] <= '0;
    end else begin
      if (flush)       r_v <= '0;
      else if (!pause) r_v <= {r_v[STAGES-2:0], in_valid};
      if (w_en) begin
        r_a[0] <= a >> SLW;
        r_b[0] <= b >> SLW;
        for (int k = 1; k < STAGES-1; k++) begin
          r_a[k] <= r_a[k-1] >> SLW;
          r_b[k] <= r_b[k-1] >> SLW;
        end
        for (int k = 1; k < STAGES; k++) r_s[k] <= w_done[k-1];
      end
    end
  end

  assign sum       = w_done[STAGES-1];
  assign cout      = w_scout[STAGES-1];
  assign out_valid = r_v[STAGES-1];

endmodule
